// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver for dealer/player scores, with frame-aligned double buffering.
// seg/an are registered one cycle behind the scan index; load is always accepted and load_ack pulses one cycle after the commit.
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_FRAMES   = 125,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [5:0] dealer_score,
    input  logic [5:0] player_score,
    input  logic       hide_dealer,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       load_ack
);

    localparam int             CW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int             FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0]     SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [CW-1:0]  TICK_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] tick_cnt;
    logic [1:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic          tick;
    logic          frame_end;
    logic          commit;

    logic [5:0]    act_dealer;
    logic [5:0]    act_player;
    logic [5:0]    pend_dealer;
    logic [5:0]    pend_player;
    logic          pend;

    logic [5:0]    sel_score;
    logic [3:0]    digit;
    logic [6:0]    pat;

    assign tick      = (tick_cnt == TICK_LAST);
    assign frame_end = tick && (idx == 2'd3);
    assign commit    = frame_end && (load || pend);

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load landing on frame_end bypasses the pending buffer so it shows in the very next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_dealer  <= '0;
            act_player  <= '0;
            pend_dealer <= '0;
            pend_player <= '0;
            pend        <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            load_ack <= commit;
            if (frame_end && load) begin
                act_dealer <= dealer_score;
                act_player <= player_score;
                pend       <= 1'b0;
            end else if (frame_end && pend) begin
                act_dealer <= pend_dealer;
                act_player <= pend_player;
                pend       <= 1'b0;
            end else if (load) begin
                pend_dealer <= dealer_score;
                pend_player <= player_score;
                pend        <= 1'b1;
            end
        end
    end

    // Slot map: idx[1] selects dealer, idx[0] selects the tens digit.
    always_comb begin
        sel_score = idx[1] ? act_dealer : act_player;
        digit     = idx[0] ? 4'(sel_score / 6'd10) : 4'(sel_score % 6'd10);
        pat       = enc(digit);
        if (idx[0] && (sel_score < 6'd10)) begin
            pat = 7'h00;
        end
        if (!blink_phase && (sel_score > 6'd21)) begin
            pat = 7'h00;
        end
        if (idx[1] && hide_dealer) begin
            pat = 7'h40;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_OFF;
            an  <= 4'hF;
        end else begin
            seg <= SEG_ACTIVE_LOW ? ~pat : pat;
            an  <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a fast scan (4 cycles/slot, 2 frames per blink half-period).
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load;
    logic [5:0] dealer_score;
    logic [5:0] player_score;
    logic       hide_dealer;
    logic [6:0] seg;
    logic [3:0] an;
    logic       load_ack;

    int checks = 0;
    int passed = 0;
    int ack_cnt = 0;

    typedef struct packed {
        logic [5:0]      p;
        logic [5:0]      d;
        logic            hide;
        logic [3:0][6:0] s;
    } vec_t;

    vec_t vecs[5];

    seg7_scan_driver #(
        .REFRESH_DIV   (4),
        .BLINK_FRAMES  (2),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .dealer_score(dealer_score),
        .player_score(player_score),
        .hide_dealer (hide_dealer),
        .seg         (seg),
        .an          (an),
        .load_ack    (load_ack)
    );

    always #5 clk = ~clk;

    // Count ack cycles at posedge so negedge-driven code reads a settled total.
    always @(posedge clk) begin
        if (load_ack) ack_cnt++;
    end

    function automatic vec_t mk(input logic [5:0] p, input logic [5:0] d, input logic h,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3);
        vec_t v;
        v.p = p; v.d = d; v.hide = h;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Waits for the first cycle on which an switches to the target slot.
    task automatic wait_slot(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        prev = an;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (an == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
    endtask

    task automatic check_slot(input string name, input int k, input logic [6:0] exp);
        bit         ok;
        logic [3:0] target;
        target = ~(4'b0001 << k);
        wait_slot(target, ok);
        chk({name, "_found"}, 32'(ok), 32'd1);
        chk(name, 32'(seg), 32'(exp));
    endtask

    task automatic wait_ack(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (load_ack) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic do_load(input logic [5:0] p, input logic [5:0] d);
        player_score = p;
        dealer_score = d;
        load         = 1'b1;
        @(negedge clk);
        load         = 1'b0;
    endtask

    initial begin
        bit ok;
        int a0;

        vecs[0] = mk(6'd17, 6'd5,  1'b1, 7'h78, 7'h79, 7'h3F, 7'h3F);
        vecs[1] = mk(6'd0,  6'd20, 1'b0, 7'h40, 7'h7F, 7'h40, 7'h24);
        vecs[2] = mk(6'd9,  6'd10, 1'b0, 7'h10, 7'h7F, 7'h40, 7'h79);
        vecs[3] = mk(6'd21, 6'd19, 1'b0, 7'h79, 7'h24, 7'h10, 7'h79);
        vecs[4] = mk(6'd4,  6'd30, 1'b1, 7'h19, 7'h7F, 7'h3F, 7'h3F);

        rst_n = 1'b0; load = 1'b0; hide_dealer = 1'b0;
        dealer_score = '0; player_score = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_ack", 32'(load_ack), 32'h0);
        rst_n = 1'b1;
        check_slot("init_s0", 0, 7'h40);
        check_slot("init_s1", 1, 7'h7F);
        check_slot("init_s2", 2, 7'h40);
        check_slot("init_s3", 3, 7'h7F);

        // Mid-frame load must not disturb the rest of the current frame.
        wait_slot(4'b1101, ok);
        a0 = ack_cnt;
        do_load(6'd17, 6'd5);
        check_slot("mid_old_s2", 2, 7'h40);
        chk("mid_no_early_ack", 32'(ack_cnt - a0), 32'd0);
        check_slot("mid_old_s3", 3, 7'h7F);
        wait_ack("mid_ack");
        @(negedge clk);
        chk("mid_ack_pulse", 32'(load_ack), 32'd0);
        check_slot("mid_s0", 0, 7'h78);
        check_slot("mid_s1", 1, 7'h79);
        check_slot("mid_s2", 2, 7'h12);
        check_slot("mid_s3", 3, 7'h7F);
        chk("mid_ack_count", 32'(ack_cnt - a0), 32'd1);

        for (int i = 0; i < 5; i++) begin
            hide_dealer = vecs[i].hide;
            wait_slot(4'b1101, ok);
            do_load(vecs[i].p, vecs[i].d);
            wait_ack($sformatf("vec%0d_ack", i));
            for (int k = 0; k < 4; k++) begin
                check_slot($sformatf("vec%0d_s%0d", i, k), k, vecs[i].s[k]);
            end
        end
        hide_dealer = 1'b0;

        // Two loads in one frame: latest wins, one ack.
        wait_slot(4'b1110, ok);
        a0 = ack_cnt;
        do_load(6'd10, 6'd4);
        @(negedge clk);
        do_load(6'd20, 6'd8);
        wait_ack("dbl_ack");
        @(negedge clk);
        chk("dbl_ack_pulse", 32'(load_ack), 32'd0);
        check_slot("dbl_s0", 0, 7'h40);
        check_slot("dbl_s1", 1, 7'h24);
        check_slot("dbl_s2", 2, 7'h00);
        check_slot("dbl_s3", 3, 7'h7F);
        repeat (20) @(negedge clk);
        chk("dbl_ack_count", 32'(ack_cnt - a0), 32'd1);

        // Load sampled exactly on frame_end (third cycle showing slot 3).
        wait_slot(4'b0111, ok);
        @(negedge clk);
        @(negedge clk);
        a0 = ack_cnt;
        do_load(6'd12, 6'd3);
        chk("fe_ack_next", 32'(load_ack), 32'd1);
        check_slot("fe_s0", 0, 7'h24);
        check_slot("fe_s1", 1, 7'h79);
        check_slot("fe_s2", 2, 7'h30);
        check_slot("fe_s3", 3, 7'h7F);
        repeat (20) @(negedge clk);
        chk("fe_ack_count", 32'(ack_cnt - a0), 32'd1);

        // Reset while a load is pending.
        wait_slot(4'b1110, ok);
        do_load(6'd17, 6'd5);
        rst_n = 1'b0;
        #1;
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_seg", 32'(seg), 32'h7F);
        chk("mrst_ack", 32'(load_ack), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a0 = ack_cnt;
        check_slot("mrst_s0", 0, 7'h40);
        check_slot("mrst_s1", 1, 7'h7F);
        check_slot("mrst_s2", 2, 7'h40);
        check_slot("mrst_s3", 3, 7'h7F);
        repeat (20) @(negedge clk);
        chk("mrst_no_ack", 32'(ack_cnt - a0), 32'd0);

        // Bust blink from a known phase: frames 1,4,5 visible, 2,3 blank.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_load(6'd25, 6'd5);
        wait_ack("blink_ack");
        for (int f = 1; f <= 5; f++) begin
            bit vis;
            vis = (f == 1) || (f == 4) || (f == 5);
            check_slot($sformatf("blink_f%0d_s0", f), 0, vis ? 7'h12 : 7'h7F);
            check_slot($sformatf("blink_f%0d_s1", f), 1, vis ? 7'h24 : 7'h7F);
            check_slot($sformatf("blink_f%0d_s2", f), 2, 7'h12);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
